// File: rtl/dual_wb_if.sv
// MEM->WB pair, register-file write ports and ID-stage bypass lookups of the dual-issue writeback stage.
// There is no back-pressure: mem_validN marks a real instruction in lane N, and rf_weN alone qualifies a write.
interface dual_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              mem_valid1;
  logic              mem_valid2;
  logic              mem_regwrite1;
  logic              mem_regwrite2;
  logic [ADDR_W-1:0] mem_rd1;
  logic [ADDR_W-1:0] mem_rd2;
  logic [DATA_W-1:0] mem_result1;
  logic [DATA_W-1:0] mem_result2;

  logic              rf_we1;
  logic              rf_we2;
  logic [ADDR_W-1:0] rf_waddr1;
  logic [ADDR_W-1:0] rf_waddr2;
  logic [DATA_W-1:0] rf_wdata1;
  logic [DATA_W-1:0] rf_wdata2;

  logic [ADDR_W-1:0] byp_raddr [0:3];
  logic              byp_hit   [0:3];
  logic [DATA_W-1:0] byp_data  [0:3];

  modport master (
    output mem_valid1, mem_valid2, mem_regwrite1, mem_regwrite2,
           mem_rd1, mem_rd2, mem_result1, mem_result2, byp_raddr,
    input  rf_we1, rf_we2, rf_waddr1, rf_waddr2, rf_wdata1, rf_wdata2,
           byp_hit, byp_data
  );

  modport slave (
    input  mem_valid1, mem_valid2, mem_regwrite1, mem_regwrite2,
           mem_rd1, mem_rd2, mem_result1, mem_result2, byp_raddr,
    output rf_we1, rf_we2, rf_waddr1, rf_waddr2, rf_wdata1, rf_wdata2,
           byp_hit, byp_data
  );
endinterface

// File: rtl/dual_wb_stage.sv
// MEM/WB pipeline register for the dual-issue pipeline: drives both register-file write ports,
// resolves same-destination pairs, serves WB bypass lookups and counts retired instructions.
module dual_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_stall,
  input  logic             wb_flush,
  dual_wb_if.slave         bus,
  output logic [CNT_W-1:0] retired_cnt
);

  logic              wb_valid1;
  logic              wb_valid2;
  logic              wb_regwrite1;
  logic              wb_regwrite2;
  logic [ADDR_W-1:0] wb_rd1;
  logic [ADDR_W-1:0] wb_rd2;
  logic [DATA_W-1:0] wb_result1;
  logic [DATA_W-1:0] wb_result2;

  logic              we1_raw;
  logic              we1;
  logic              we2;
  logic [1:0]        n_retire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid1    <= 1'b0;
      wb_valid2    <= 1'b0;
      wb_regwrite1 <= 1'b0;
      wb_regwrite2 <= 1'b0;
      wb_rd1       <= '0;
      wb_rd2       <= '0;
      wb_result1   <= '0;
      wb_result2   <= '0;
    end else if (wb_flush) begin
      wb_valid1 <= 1'b0;
      wb_valid2 <= 1'b0;
    end else if (!wb_stall) begin
      wb_valid1    <= bus.mem_valid1;
      wb_valid2    <= bus.mem_valid2;
      wb_regwrite1 <= bus.mem_regwrite1;
      wb_regwrite2 <= bus.mem_regwrite2;
      wb_rd1       <= bus.mem_rd1;
      wb_rd2       <= bus.mem_rd2;
      wb_result1   <= bus.mem_result1;
      wb_result2   <= bus.mem_result2;
    end
  end

  // The held pair retires in the first non-stalled cycle, even when flush squashes the incoming pair.
  assign n_retire = {1'b0, wb_valid1} + {1'b0, wb_valid2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
    end else if (!wb_stall) begin
      retired_cnt <= retired_cnt + CNT_W'(n_retire);
    end
  end

  // Same-destination pair: the younger lane 2 owns the register, so lane 1 is dropped.
  assign we1_raw = wb_valid1 & wb_regwrite1 & (wb_rd1 != '0) & ~wb_stall;
  assign we2     = wb_valid2 & wb_regwrite2 & (wb_rd2 != '0) & ~wb_stall;
  assign we1     = we1_raw & ~(we2 & (wb_rd1 == wb_rd2));

  always_comb begin
    bus.rf_we1    = we1;
    bus.rf_we2    = we2;
    bus.rf_waddr1 = wb_rd1;
    bus.rf_waddr2 = wb_rd2;
    bus.rf_wdata1 = wb_result1;
    bus.rf_wdata2 = wb_result2;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.byp_hit[i]  = 1'b0;
      bus.byp_data[i] = '0;
      if (we2 && (bus.byp_raddr[i] == wb_rd2)) begin
        bus.byp_hit[i]  = 1'b1;
        bus.byp_data[i] = wb_result2;
      end else if (we1 && (bus.byp_raddr[i] == wb_rd1)) begin
        bus.byp_hit[i]  = 1'b1;
        bus.byp_data[i] = wb_result1;
      end
    end
  end

endmodule
